// File: rtl/addd_seq_cs.sv
//------------------------------------------------------------------------------
// addd_seq_cs
//
// Multi-cycle carry-select add/subtract unit. The result is double width:
// {res_high,res_low}. One CHUNK-bit slice of the operands is resolved per
// clock. Both slice sums (carry-in 0 and carry-in 1) are formed, and the
// registered carry from the previous slice selects between them.
//
// Operation flow:
//   IDLE --accept--> RUN (NCH cycles, one slice each) --> DONE --out_ready--> IDLE
//   flush returns to IDLE from any state on the next edge.
//
// Subtraction is performed as a + ~b + 1. The inverted operand is latched on
// accept, and the carry register is preset to 1. After the last slice:
//   add : res_high = zero-extended final carry
//   sub : res_high = all-ones when a borrow occurred (final carry 0), else 0
//
// Optional feature, enabled by defining ADDD_SEQ_FLAGS_EN:
//   zero : res_low == 0
//   ovf  : signed two's-complement overflow of the WIDTH-bit operation
//   Both flags are registered on the edge that enters DONE and are held until
//   the next DONE.
//
// Parameters:
//   WIDTH  operand width in bits (a multiple of CHUNK)
//   CHUNK  bits resolved per cycle (1..WIDTH)
//
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   in_valid   in   1      operands presented
//   in_ready   out  1      unit idle, can accept operands
//   sub        in   1      0: a+b, 1: a-b (sampled on accept)
//   a, b       in   WIDTH  unsigned operands (sampled on accept)
//   flush      in   1      synchronous abort back to IDLE
//   out_valid  out  1      result is held on res_high/res_low
//   out_ready  in   1      consumer takes the result
//   res_high   out  WIDTH  extension word (carry or sign-extended borrow)
//   res_low    out  WIDTH  low word of a+b or a-b
//   busy       out  1      unit is in RUN
//   zero, ovf  out  1      result flags (only with ADDD_SEQ_FLAGS_EN)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module addd_seq_cs #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_high,
    output logic [WIDTH-1:0] res_low,
    output logic             busy
`ifdef ADDD_SEQ_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    // Width for a bit offset of up to WIDTH-CHUNK.
    localparam int SW  = $clog2(WIDTH) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateE;

    stateE state;
    stateE stateNext;

    // Latched operation
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bxReg;
    logic             subReg;
    logic             carry;
    logic [IW-1:0]    idx;

    // Slice datapath
    logic [SW-1:0]    sliceSh;
    logic [CHUNK-1:0] aSlice;
    logic [CHUNK-1:0] bSlice;
    logic [CHUNK:0]   sumC0;
    logic [CHUNK:0]   sumC1;
    logic [CHUNK:0]   sumSel;
    logic [WIDTH-1:0] sliceMask;
    logic [WIDTH-1:0] resLowNext;

    logic accept;
    logic runStep;
    logic lastSlice;

    //--------------------------------------------------------------------------
    // Helper functions
    //--------------------------------------------------------------------------

    // Extension word. For add it is the final carry. For sub it is the borrow
    // sign-extended, and a borrow shows up as a missing final carry.
    function automatic logic [WIDTH-1:0] extendWord(input logic isSub,
                                                    input logic carryOut);
        if (isSub)
            return carryOut ? '0 : '1;
        else
            return WIDTH'(carryOut);
    endfunction

    // Signed overflow of aMsb + bxMsb (+cin). It occurs only when both addend
    // signs agree and the result sign differs from them.
    function automatic logic signedOverflow(input logic aMsb,
                                            input logic bxMsb,
                                            input logic resMsb);
        return (aMsb == bxMsb) && (resMsb != aMsb);
    endfunction

    //--------------------------------------------------------------------------
    // Handshake qualifiers (flush wins over everything)
    //--------------------------------------------------------------------------
    assign accept    = (state == IDLE) && in_valid && !flush;
    assign runStep   = (state == RUN) && !flush;
    assign lastSlice = runStep && (idx == LAST_IDX);

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        if (flush) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid)        stateNext = RUN;
                RUN:     if (idx == LAST_IDX) stateNext = DONE;
                DONE:    if (out_ready)       stateNext = IDLE;
                default:                      stateNext = IDLE;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // FSM: outputs (decoded from the registered state)
    //--------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    //--------------------------------------------------------------------------
    // Carry-select slice. Both candidate sums are formed independently, and the
    // registered carry from the previous slice picks one.
    //--------------------------------------------------------------------------
    assign sliceSh = SW'(idx) * SW'(CHUNK);
    assign aSlice  = CHUNK'(aReg  >> sliceSh);
    assign bSlice  = CHUNK'(bxReg >> sliceSh);

    assign sumC0  = {1'b0, aSlice} + {1'b0, bSlice};
    assign sumC1  = {1'b0, aSlice} + {1'b0, bSlice} + (CHUNK+1)'(1);
    assign sumSel = carry ? sumC1 : sumC0;

    // res_low with the current slice merged in. This value is also used for the
    // flags, so they see the final word on the last slice.
    assign sliceMask  = WIDTH'({CHUNK{1'b1}}) << sliceSh;
    assign resLowNext = (res_low & ~sliceMask)
                      | (WIDTH'(sumSel[CHUNK-1:0]) << sliceSh);

    //--------------------------------------------------------------------------
    // Operand latch, slice accumulation, and result registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aReg     <= '0;
            bxReg    <= '0;
            subReg   <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
            res_low  <= '0;
            res_high <= '0;
`ifdef ADDD_SEQ_FLAGS_EN
            zero     <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else if (accept) begin
            // Subtraction becomes a + ~b with a carry-in of 1.
            aReg   <= a;
            bxReg  <= sub ? ~b : b;
            subReg <= sub;
            carry  <= sub;
            idx    <= '0;
        end else if (runStep) begin
            res_low <= resLowNext;
            carry   <= sumSel[CHUNK];
            if (lastSlice) begin
                idx      <= '0;
                res_high <= extendWord(subReg, sumSel[CHUNK]);
`ifdef ADDD_SEQ_FLAGS_EN
                zero     <= (resLowNext == '0);
                ovf      <= signedOverflow(aReg[WIDTH-1], bxReg[WIDTH-1],
                                           resLowNext[WIDTH-1]);
`endif
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule
